// File: rtl/mem_pkg.sv
// Shared constants for the complex-number CPU memory subsystem:
// default port geometry, opcode encodings and the peripheral window base.
package mem_pkg;

  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_DATA_BYTES   = 2;
  localparam int DEF_INST_BYTES   = 4;
  localparam int DEF_PERIPH_BYTES = 2;

  localparam logic [7:0] ADD_OP  = 8'h00;
  localparam logic [7:0] SUB_OP  = 8'h01;
  localparam logic [7:0] MUL_OP  = 8'h02;
  localparam logic [7:0] LD_OP   = 8'h03;
  localparam logic [7:0] ST_OP   = 8'h04;
  localparam logic [7:0] JMP_OP  = 8'h05;
  localparam logic [7:0] IMED_LD = 8'h06;

  // The window occupies the last periphBytes bytes of the address space.
  function automatic int periphBase(input int addrWidth, input int periphBytes);
    return int'((32'd1 << addrWidth) - 32'(periphBytes));
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One byte lane of the interleaved memory: synchronous write, two read ports
// (fetch and load/store). Contents are deliberately not reset.
module mem_bank #(
  parameter int ROW_BITS = 14
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ROW_BITS-1:0] wrAddr,
  input  logic [7:0]          wrData,
  input  logic [ROW_BITS-1:0] rdAddrA,
  output logic [7:0]          rdDataA,
  input  logic [ROW_BITS-1:0] rdAddrB,
  output logic [7:0]          rdDataB
);

  logic [7:0] mem_r [0:(2**ROW_BITS)-1];

  // byte write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wrAddr] <= wrData;
    end
  end

  assign rdDataA = mem_r[rdAddrA];
  assign rdDataB = mem_r[rdAddrB];

endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory: byte-interleaved banks, registered reads with
// valid strobes, per-byte store enables and a reset-clearable peripheral window.
module unified_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_BYTES   = DEF_DATA_BYTES,
  parameter int INST_BYTES   = DEF_INST_BYTES,
  parameter int PERIPH_BYTES = DEF_PERIPH_BYTES,
  parameter     INIT_FILE    = ""
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instReq,
  input  logic [ADDR_WIDTH-1:0]     instAddr,
  output logic                      instValid,
  output logic [8*INST_BYTES-1:0]   instOut,
  input  logic                      dataReq,
  input  logic                      dataWe,
  input  logic [ADDR_WIDTH-1:0]     dataAddr,
  input  logic [DATA_BYTES-1:0]     dataBe,
  input  logic [8*DATA_BYTES-1:0]   inData,
  output logic                      dataValid,
  output logic [8*DATA_BYTES-1:0]   dataOut,
  output logic [8*PERIPH_BYTES-1:0] PeripheralBuffer,
  output logic                      periphUpdated,
  input  logic                      periphAck
);

  localparam int NB       = (DATA_BYTES > INST_BYTES) ? DATA_BYTES : INST_BYTES;
  localparam int BB       = $clog2(NB);
  localparam int ROW_BITS = ADDR_WIDTH - BB;
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK   = ADDR_WIDTH'(NB - 1);
  localparam logic [ADDR_WIDTH-1:0] PERIPH_BASE = ADDR_WIDTH'(periphBase(ADDR_WIDTH, PERIPH_BYTES));

  logic [ROW_BITS-1:0]       instRow_s     [NB];
  logic [ROW_BITS-1:0]       dataRow_s     [NB];
  logic [7:0]                bankWrData_s  [NB];
  logic [7:0]                instRd_s      [NB];
  logic [7:0]                dataRd_s      [NB];
  logic [NB-1:0]             bankWe_s;
  logic [8*INST_BYTES-1:0]   instNext_s;
  logic [8*DATA_BYTES-1:0]   dataNext_s;
  logic [PERIPH_BYTES-1:0]   periphWe_s;
  logic [8*PERIPH_BYTES-1:0] periphWd_s;

  logic                      instValid_r;
  logic [8*INST_BYTES-1:0]   instOut_r;
  logic                      dataValid_r;
  logic [8*DATA_BYTES-1:0]   dataOut_r;
  logic [8*PERIPH_BYTES-1:0] periphBuf_r;
  logic                      periphUpdated_r;

  // per-bank row address, write lane select and store gating
  always_comb begin
    logic [ADDR_WIDTH-1:0] instLane;
    logic [ADDR_WIDTH-1:0] dataLane;
    logic [ADDR_WIDTH-1:0] dataByteAddr;
    logic [7:0]            wrByte;
    logic                  beBit;
    instLane     = '0;
    dataLane     = '0;
    dataByteAddr = '0;
    wrByte       = 8'h00;
    beBit        = 1'b0;
    bankWe_s     = '0;
    for (int b = 0; b < NB; b++) begin
      // lane that lands in bank b for a word starting at the request address
      instLane        = (ADDR_WIDTH'(b) - instAddr) & LANE_MASK;
      dataLane        = (ADDR_WIDTH'(b) - dataAddr) & LANE_MASK;
      instRow_s[b]    = ROW_BITS'((instAddr + instLane) >> BB);
      dataByteAddr    = dataAddr + dataLane;
      dataRow_s[b]    = ROW_BITS'(dataByteAddr >> BB);
      wrByte          = 8'h00;
      beBit           = 1'b0;
      for (int i = 0; i < DATA_BYTES; i++) begin
        wrByte = (dataLane == ADDR_WIDTH'(i)) ? inData[8*i +: 8] : wrByte;
        beBit  = (dataLane == ADDR_WIDTH'(i)) ? dataBe[i] : beBit;
      end
      bankWrData_s[b] = wrByte;
      // window bytes live in registers, so the array copy is never written
      bankWe_s[b]     = rst_n & dataReq & dataWe & beBit & (dataByteAddr < PERIPH_BASE);
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_bank
    mem_bank #(.ROW_BITS(ROW_BITS)) uBank (
      .clk     (clk),
      .we      (bankWe_s[g]),
      .wrAddr  (dataRow_s[g]),
      .wrData  (bankWrData_s[g]),
      .rdAddrA (instRow_s[g]),
      .rdDataA (instRd_s[g]),
      .rdAddrB (dataRow_s[g]),
      .rdDataB (dataRd_s[g])
    );
  end

  // lane rotation and window substitution for both read ports
  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    logic [7:0]            laneByte;
    a          = '0;
    laneByte   = 8'h00;
    instNext_s = '0;
    dataNext_s = '0;
    for (int i = 0; i < INST_BYTES; i++) begin
      a        = instAddr + ADDR_WIDTH'(i);
      laneByte = 8'h00;
      for (int b = 0; b < NB; b++) begin
        laneByte = ((a & LANE_MASK) == ADDR_WIDTH'(b)) ? instRd_s[b] : laneByte;
      end
      for (int w = 0; w < PERIPH_BYTES; w++) begin
        laneByte = (a == PERIPH_BASE + ADDR_WIDTH'(w)) ? periphBuf_r[8*w +: 8] : laneByte;
      end
      instNext_s[8*i +: 8] = laneByte;
    end
    for (int i = 0; i < DATA_BYTES; i++) begin
      a        = dataAddr + ADDR_WIDTH'(i);
      laneByte = 8'h00;
      for (int b = 0; b < NB; b++) begin
        laneByte = ((a & LANE_MASK) == ADDR_WIDTH'(b)) ? dataRd_s[b] : laneByte;
      end
      for (int w = 0; w < PERIPH_BYTES; w++) begin
        laneByte = (a == PERIPH_BASE + ADDR_WIDTH'(w)) ? periphBuf_r[8*w +: 8] : laneByte;
      end
      dataNext_s[8*i +: 8] = laneByte;
    end
  end

  // enabled store lanes that fall inside the peripheral window
  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    logic                  hit;
    a          = '0;
    hit        = 1'b0;
    periphWe_s = '0;
    periphWd_s = '0;
    for (int w = 0; w < PERIPH_BYTES; w++) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        a   = dataAddr + ADDR_WIDTH'(i);
        hit = dataReq & dataWe & dataBe[i] & (a == PERIPH_BASE + ADDR_WIDTH'(w));
        periphWe_s[w]         = periphWe_s[w] | hit;
        periphWd_s[8*w +: 8]  = hit ? inData[8*i +: 8] : periphWd_s[8*w +: 8];
      end
    end
  end

  // read result registers: one-cycle valid pulses, data held between requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instValid_r <= 1'b0;
      instOut_r   <= '0;
      dataValid_r <= 1'b0;
      dataOut_r   <= '0;
    end else begin
      instValid_r <= instReq;
      dataValid_r <= dataReq & ~dataWe;
      if (instReq) begin
        instOut_r <= instNext_s;
      end
      if (dataReq & ~dataWe) begin
        dataOut_r <= dataNext_s;
      end
    end
  end

  // peripheral window bytes and the sticky update flag (set beats ack)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      periphBuf_r     <= '0;
      periphUpdated_r <= 1'b0;
    end else begin
      for (int w = 0; w < PERIPH_BYTES; w++) begin
        if (periphWe_s[w]) begin
          periphBuf_r[8*w +: 8] <= periphWd_s[8*w +: 8];
        end
      end
      periphUpdated_r <= (|periphWe_s) | (periphUpdated_r & ~periphAck);
    end
  end

  assign instValid        = instValid_r;
  assign instOut          = instOut_r;
  assign dataValid        = dataValid_r;
  assign dataOut          = dataOut_r;
  assign PeripheralBuffer = periphBuf_r;
  assign periphUpdated    = periphUpdated_r;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench for unified_mem_ctrl with default geometry (16-bit address,
// 2-byte data port, 4-byte fetch port, 2-byte window at 0xFFFE).
module tb_unified_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instReq;
  logic [15:0] instAddr;
  logic        instValid;
  logic [31:0] instOut;
  logic        dataReq;
  logic        dataWe;
  logic [15:0] dataAddr;
  logic [1:0]  dataBe;
  logic [15:0] inData;
  logic        dataValid;
  logic [15:0] dataOut;
  logic [15:0] PeripheralBuffer;
  logic        periphUpdated;
  logic        periphAck;

  int total = 0;
  int bad   = 0;

  unified_mem_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instReq          (instReq),
    .instAddr         (instAddr),
    .instValid        (instValid),
    .instOut          (instOut),
    .dataReq          (dataReq),
    .dataWe           (dataWe),
    .dataAddr         (dataAddr),
    .dataBe           (dataBe),
    .inData           (inData),
    .dataValid        (dataValid),
    .dataOut          (dataOut),
    .PeripheralBuffer (PeripheralBuffer),
    .periphUpdated    (periphUpdated),
    .periphAck        (periphAck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // apply one cycle of requests, then sample 1 time unit after the edge
  task automatic step(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                      input logic [15:0] da, input logic [1:0] be, input logic [15:0] d,
                      input logic ack);
    instReq = ir; instAddr = ia; dataReq = dr; dataWe = dw;
    dataAddr = da; dataBe = be; inData = d; periphAck = ack;
    @(posedge clk);
    #1;
    instReq = 1'b0; dataReq = 1'b0; dataWe = 1'b0; periphAck = 1'b0;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    step(1'b0, 16'h0000, 1'b1, 1'b1, a, be, d, 1'b0);
  endtask

  task automatic load(input logic [15:0] a);
    step(1'b0, 16'h0000, 1'b1, 1'b0, a, 2'b00, 16'h0000, 1'b0);
  endtask

  task automatic fetch(input logic [15:0] a);
    step(1'b1, a, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; instReq = 1'b0; instAddr = 16'h0000; dataReq = 1'b0; dataWe = 1'b0;
    dataAddr = 16'h0000; dataBe = 2'b00; inData = 16'h0000; periphAck = 1'b0;
    #12;
    chk("rst_instValid", {31'd0, instValid}, 32'd0);
    chk("rst_instOut", instOut, 32'h0);
    chk("rst_dataValid", {31'd0, dataValid}, 32'd0);
    chk("rst_dataOut", {16'd0, dataOut}, 32'h0);
    chk("rst_periphBuf", {16'd0, PeripheralBuffer}, 32'h0);
    chk("rst_periphUpd", {31'd0, periphUpdated}, 32'd0);
    rst_n = 1'b1;

    // preload 0x0000..0x0003 = 00,00,FC,B0 and fetch it back
    store(16'h0000, 16'h0000, 2'b11);
    store(16'h0002, 16'hB0FC, 2'b11);
    chk("store_no_valid", {31'd0, dataValid}, 32'd0);
    fetch(16'h0000);
    chk("fetch_valid", {31'd0, instValid}, 32'd1);
    chk("fetch_data", instOut, 32'hB0FC0000);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 1'b0);
    chk("fetch_valid_pulse", {31'd0, instValid}, 32'd0);
    chk("fetch_hold", instOut, 32'hB0FC0000);

    // unaligned store spanning a bank row, then immediate load
    store(16'h007F, 16'hAAAA, 2'b11);
    load(16'h007F);
    chk("load_valid", {31'd0, dataValid}, 32'd1);
    chk("load_unaligned", {16'd0, dataOut}, 32'h0000AAAA);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 1'b0);
    chk("load_valid_pulse", {31'd0, dataValid}, 32'd0);
    chk("load_hold", {16'd0, dataOut}, 32'h0000AAAA);

    // partial byte enable merges with existing bytes
    store(16'h0010, 16'hFFFF, 2'b11);
    store(16'h0012, 16'h0000, 2'b11);
    store(16'h0010, 16'h1234, 2'b01);
    load(16'h0010);
    chk("byte_enable", {16'd0, dataOut}, 32'h0000FF34);

    // fetch and store to the same bytes on one edge: fetch sees old data
    step(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0010, 2'b11, 16'hABCD, 1'b0);
    chk("rbw_fetch", instOut, 32'h0000FF34);
    chk("rbw_no_dvalid", {31'd0, dataValid}, 32'd0);
    load(16'h0010);
    chk("rbw_after", {16'd0, dataOut}, 32'h0000ABCD);

    // peripheral window and sticky flag
    store(16'hFFFE, 16'hBEEF, 2'b11);
    chk("win_buf", {16'd0, PeripheralBuffer}, 32'h0000BEEF);
    chk("win_upd", {31'd0, periphUpdated}, 32'd1);
    step(1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 2'b11, 16'h5566, 1'b1);
    chk("win_wrap_buf", {16'd0, PeripheralBuffer}, 32'h000066EF);
    chk("win_set_wins", {31'd0, periphUpdated}, 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 1'b1);
    chk("win_ack_clear", {31'd0, periphUpdated}, 32'd0);
    chk("win_ack_keep_buf", {16'd0, PeripheralBuffer}, 32'h000066EF);
    fetch(16'hFFFE);
    chk("fetch_wrap", instOut, 32'h005566EF);
    load(16'hFFFF);
    chk("load_wrap", {16'd0, dataOut}, 32'h00005566);
    load(16'h0000);
    chk("wrap_array_byte", {16'd0, dataOut}, 32'h00000055);

    // reset in the middle of a load result, with a store pending on the edge
    load(16'h0002);
    chk("pre_rst_valid", {31'd0, dataValid}, 32'd1);
    chk("pre_rst_data", {16'd0, dataOut}, 32'h0000B0FC);
    rst_n = 1'b0;
    dataReq = 1'b1; dataWe = 1'b1; dataAddr = 16'h0002; dataBe = 2'b11; inData = 16'h1111;
    #1;
    chk("mid_rst_dvalid", {31'd0, dataValid}, 32'd0);
    chk("mid_rst_dout", {16'd0, dataOut}, 32'h0);
    chk("mid_rst_iout", instOut, 32'h0);
    chk("mid_rst_buf", {16'd0, PeripheralBuffer}, 32'h0);
    chk("mid_rst_upd", {31'd0, periphUpdated}, 32'd0);
    @(posedge clk);
    #1;
    dataReq = 1'b0; dataWe = 1'b0;
    rst_n = 1'b1;
    load(16'h0002);
    chk("rst_store_dropped", {16'd0, dataOut}, 32'h0000B0FC);
    fetch(16'h0000);
    chk("rst_array_kept", instOut, 32'hB0FC0055);
    load(16'hFFFE);
    chk("rst_window_read", {16'd0, dataOut}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
